// File: rtl/subtract_seq_multibyte.sv
// Wide subtractor that walks one shared 8-bit subtract slice across NBYTES bytes, LSB first.
// The borrow chains between bytes through a register. Results update only on the done pulse.
//
// state | meaning
// IDLE  | waiting for start; d/b_out/zero hold the last result
// RUN   | one byte per clock through the shared slice; idx selects the byte

module subtract_8bit (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       b_in_i,
   output logic [7:0] d_o,
   output logic       b_out_o
);
   logic [8:0] diff;

   // The ninth bit goes to 1 exactly when a < b + b_in.
   assign diff    = {1'b0, a_i} - {1'b0, b_i} - {8'b0, b_in_i};
   assign d_o     = diff[7:0];
   assign b_out_o = diff[8];
endmodule

module subtract_seq_multibyte #(
   parameter int NBYTES = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [8*NBYTES-1:0]   a_i,
   input  logic [8*NBYTES-1:0]   b_i,
   input  logic                  b_in_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [8*NBYTES-1:0]   d_o,
   output logic                  b_out_o,
   output logic                  zero_o
);
   localparam int W    = 8 * NBYTES;
   localparam int IDXW = $clog2(NBYTES);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            borrow_q, borrow_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    shadow_q, shadow_d;
   logic [W-1:0]    d_q, d_d;
   logic            b_out_q, b_out_d;
   logic            zero_q, zero_d;
   logic            done_q, done_d;

   logic [7:0]      slice_a, slice_b, slice_d;
   logic            slice_bout;
   logic [W-1:0]    shadow_upd;
   logic [IDXW+2:0] bit_base;

   assign bit_base = {idx_q, 3'b000};
   assign slice_a  = a_q[bit_base +: 8];
   assign slice_b  = b_q[bit_base +: 8];

   subtract_8bit u_slice (
      .a_i     (slice_a),
      .b_i     (slice_b),
      .b_in_i  (borrow_q),
      .d_o     (slice_d),
      .b_out_o (slice_bout)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         shadow_q <= '0;
         d_q      <= '0;
         b_out_q  <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         a_q      <= a_d;
         b_q      <= b_d;
         shadow_q <= shadow_d;
         d_q      <= d_d;
         b_out_q  <= b_out_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      borrow_d   = borrow_q;
      a_d        = a_q;
      b_d        = b_q;
      shadow_d   = shadow_q;
      d_d        = d_q;
      b_out_d    = b_out_q;
      zero_d     = zero_q;
      done_d     = 1'b0;
      // Shadow including this cycle's byte, so the last byte lands in d on the done edge.
      shadow_upd = shadow_q;
      shadow_upd[bit_base +: 8] = slice_d;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               a_d      = a_i;
               b_d      = b_i;
               borrow_d = b_in_i;
               idx_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            shadow_d = shadow_upd;
            borrow_d = slice_bout;
            idx_d    = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
               d_d     = shadow_upd;
               b_out_d = slice_bout;
               zero_d  = (shadow_upd == '0);
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o  = (state_q == RUN);
   assign done_o  = done_q;
   assign d_o     = d_q;
   assign b_out_o = b_out_q;
   assign zero_o  = zero_q;
endmodule
